// File: rtl/mem_ctrl_pkg.sv
// Shared encodings for the IF/MEM byte-bus controller.
package mem_ctrl_pkg;

    typedef enum logic [1:0] {ST_IDLE, ST_READ, ST_WRITE, ST_DONE} state_t;

    localparam logic [1:0]  MEM_LEN_B = 2'd0;
    localparam logic [1:0]  MEM_LEN_H = 2'd1;
    localparam logic [1:0]  MEM_LEN_W = 2'd2;
    localparam logic [31:0] IO_BASE   = 32'h0003_0000;

    // Illegal length code 3 falls through to a full word.
    function automatic logic [2:0] len_bytes(input logic [1:0] len);
        case (len)
            MEM_LEN_B: return 3'd1;
            MEM_LEN_H: return 3'd2;
            default:   return 3'd4;
        endcase
    endfunction

    function automatic logic [3:0] len_mask(input logic [2:0] n);
        logic [4:0] m;
        m = (5'd1 << n) - 5'd1;
        return m[3:0];
    endfunction

endpackage

// File: rtl/mem_byte_seq.sv
// Byte issue sequencer: walks base..base+N-1 on the bus, tracks which bytes are
// done, rewinds after a paused edge and flags the edge that completes the transfer.
module mem_byte_seq
    import mem_ctrl_pkg::*;
#(
    parameter int ADDR_W = 32
) (
    input  logic              clk_in,
    input  logic              rst_in,
    input  logic              rdy_in,
    input  logic              i_start,
    input  logic              i_wr,
    input  logic              i_abort,
    input  logic [ADDR_W-1:0] i_base,
    input  logic [2:0]        i_len,
    output logic [ADDR_W-1:0] o_ram_a,
    output logic              o_ram_wr,
    output logic              o_cap,
    output logic [1:0]        o_cap_idx,
    output logic [1:0]        o_nxt_idx,
    output logic              o_nxt_vld,
    output logic              o_done
);

    logic              r_act, r_wr, r_ivld, r_pvld;
    logic [ADDR_W-1:0] r_base;
    logic [2:0]        r_len;
    logic [1:0]        r_iss, r_pidx;
    logic [3:0]        r_cmask;

    logic              w_inflight, w_wdone;
    logic [3:0]        w_mask_n;

    // The RAM is free-running: an address presented at an edge is read (or
    // written) regardless of rdy_in; only the controller discards returned data.
    always_comb begin
        w_inflight = r_ivld && !r_wr;
        w_wdone    = r_act && r_wr && o_ram_wr;
        o_cap      = r_act && !r_wr && r_pvld && rdy_in;
        o_cap_idx  = r_pidx;
        w_mask_n   = r_cmask;
        if (o_cap)   w_mask_n[r_pidx] = 1'b1;
        if (w_wdone) w_mask_n[r_iss]  = 1'b1;
        o_done     = r_act && rdy_in && (w_mask_n == len_mask(r_len));
        // Lowest byte neither finished nor already on its way back.
        o_nxt_idx  = 2'd0;
        o_nxt_vld  = 1'b0;
        for (int k = 3; k >= 0; k--) begin
            if (k < int'(r_len) && !w_mask_n[k] && !(w_inflight && r_iss == 2'(k))) begin
                o_nxt_idx = 2'(k);
                o_nxt_vld = 1'b1;
            end
        end
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            r_act    <= 1'b0;
            r_wr     <= 1'b0;
            r_ivld   <= 1'b0;
            r_pvld   <= 1'b0;
            r_base   <= '0;
            r_len    <= 3'd0;
            r_iss    <= 2'd0;
            r_pidx   <= 2'd0;
            r_cmask  <= 4'd0;
            o_ram_a  <= '0;
            o_ram_wr <= 1'b0;
        end else if (i_abort) begin
            r_act    <= 1'b0;
            r_ivld   <= 1'b0;
            r_pvld   <= 1'b0;
            o_ram_wr <= 1'b0;
        end else if (i_start) begin
            r_act    <= 1'b1;
            r_wr     <= i_wr;
            r_base   <= i_base;
            r_len    <= i_len;
            r_iss    <= 2'd0;
            r_ivld   <= 1'b1;
            r_pvld   <= 1'b0;
            r_cmask  <= 4'd0;
            o_ram_a  <= i_base;
            o_ram_wr <= i_wr;
        end else if (r_act) begin
            r_cmask <= w_mask_n;
            r_pidx  <= r_iss;
            r_pvld  <= w_inflight;
            if (o_done) begin
                r_act    <= 1'b0;
                r_ivld   <= 1'b0;
                o_ram_wr <= 1'b0;
            end else begin
                r_ivld <= o_nxt_vld;
                if (o_nxt_vld) begin
                    r_iss   <= o_nxt_idx;
                    o_ram_a <= r_base + ADDR_W'(o_nxt_idx);
                end
                o_ram_wr <= r_wr && o_nxt_vld && rdy_in;
            end
        end
    end

endmodule

// File: rtl/mem_ctrl.sv
// Byte-bus arbiter between IF fetches and MEM loads/stores; MEM has fixed
// priority. Assembles read bytes little-endian and pulses done for one cycle.
module mem_ctrl
    import mem_ctrl_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk_in,
    input  logic              rst_in,
    input  logic              rdy_in,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    input  logic              if_flush,
    output logic              if_done,
    output logic [DATA_W-1:0] if_data,
    input  logic              mem_req,
    input  logic              mem_wr,
    input  logic [1:0]        mem_len,
    input  logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_wdata,
    output logic              mem_done,
    output logic [DATA_W-1:0] mem_rdata,
    input  logic [7:0]        ram_din,
    output logic [7:0]        ram_dout,
    output logic [ADDR_W-1:0] ram_a,
    output logic              ram_wr
);

    state_t            r_state, w_nstate;
    logic              r_own_if;
    logic [DATA_W-1:0] r_wdata, r_rbuf, w_rbuf_n;

    logic              w_start, w_gnt_mem, w_abort;
    logic              w_cap, w_seq_done, w_nxt_vld;
    logic [1:0]        w_cap_idx, w_nxt_idx;

    always_comb begin
        w_nstate  = r_state;
        w_start   = 1'b0;
        w_gnt_mem = 1'b0;
        w_abort   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (rdy_in) begin
                    if (mem_req) begin
                        w_gnt_mem = 1'b1;
                        w_start   = 1'b1;
                        w_nstate  = mem_wr ? ST_WRITE : ST_READ;
                    end else if (if_req && !if_flush) begin
                        w_start  = 1'b1;
                        w_nstate = ST_READ;
                    end
                end
            end
            ST_READ: begin
                if (if_flush && r_own_if) begin
                    w_abort  = 1'b1;
                    w_nstate = ST_IDLE;
                end else if (w_seq_done) begin
                    w_nstate = ST_DONE;
                end
            end
            ST_WRITE: if (w_seq_done) w_nstate = ST_DONE;
            ST_DONE:  if (rdy_in)     w_nstate = ST_IDLE;
            default:  w_nstate = ST_IDLE;
        endcase
    end

    always_comb begin
        w_rbuf_n = r_rbuf;
        if (w_cap) w_rbuf_n[{w_cap_idx, 3'b000} +: 8] = ram_din;
    end

    mem_byte_seq #(.ADDR_W(ADDR_W)) u_seq (
        .clk_in    (clk_in),
        .rst_in    (rst_in),
        .rdy_in    (rdy_in),
        .i_start   (w_start),
        .i_wr      (w_gnt_mem && mem_wr),
        .i_abort   (w_abort),
        .i_base    (w_gnt_mem ? mem_addr : if_addr),
        .i_len     (w_gnt_mem ? len_bytes(mem_len) : 3'd4),
        .o_ram_a   (ram_a),
        .o_ram_wr  (ram_wr),
        .o_cap     (w_cap),
        .o_cap_idx (w_cap_idx),
        .o_nxt_idx (w_nxt_idx),
        .o_nxt_vld (w_nxt_vld),
        .o_done    (w_seq_done)
    );

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            r_state   <= ST_IDLE;
            r_own_if  <= 1'b0;
            r_wdata   <= '0;
            r_rbuf    <= '0;
            ram_dout  <= 8'd0;
            if_done   <= 1'b0;
            mem_done  <= 1'b0;
            if_data   <= '0;
            mem_rdata <= '0;
        end else begin
            r_state <= w_nstate;
            if (w_start) begin
                r_own_if <= !w_gnt_mem;
                r_wdata  <= mem_wdata;
                r_rbuf   <= '0;
                ram_dout <= mem_wdata[7:0];
            end else begin
                if (w_cap) r_rbuf <= w_rbuf_n;
                if (r_state == ST_WRITE && w_nxt_vld)
                    ram_dout <= r_wdata[{w_nxt_idx, 3'b000} +: 8];
            end
            // A paused DONE cycle keeps the pulse up along with the state.
            if (!(r_state == ST_DONE && !rdy_in)) begin
                if_done  <= w_seq_done && r_own_if;
                mem_done <= w_seq_done && !r_own_if;
            end
            if (w_seq_done && r_own_if) if_data <= w_rbuf_n;
            if (w_seq_done && !r_own_if && r_state == ST_READ) mem_rdata <= w_rbuf_n;
        end
    end

endmodule
